// File: rtl/lut3_sweep_ctrl.sv
// lut3_sweep_ctrl: walks a 3-input LUT through all eight input vectors.
// Each vector is held for SETTLE_CYCLES cycles, and then the LUT output is
// compared with the latched expected truth table. The block reports the
// mismatch count, the lowest failing vector and a pass flag.
//
// Handshake: start is a single-cycle request that is accepted only in IDLE.
// busy is high from the cycle after acceptance through the done cycle. done
// is a one-cycle pulse, and in that same cycle pass/err_count/fail_idx
// already hold the final results. The results stay stable until the next
// accepted start. There is no backpressure.
module lut3_sweep_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] init,
    input  logic       dut_o,
    output logic [2:0] dut_i,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic [2:0] fail_idx,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

    state_t     state;
    state_t     state_next;
    logic [7:0] init_q;
    logic [2:0] idx;
    logic [7:0] cnt;
    logic       mismatch;
    logic [3:0] err_next;

    // Compare the LUT output against the expected bit. The error count saturates at 8.
    always_comb begin
        mismatch = 1'b0;
        err_next = err_count;
        if (state == CHECK) begin
            mismatch = (dut_o != init_q[idx]);
        end
        if (mismatch && (err_count != 4'd8)) begin
            err_next = err_count + 4'd1;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SETTLE;
            SETTLE:  if (cnt == 8'd0) state_next = CHECK;
            CHECK:   state_next = (idx == 3'd7) ? DONE : SETTLE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: latch the truth table, step the vector index and settle counter, and accumulate results.
    always_ff @(posedge clk) begin
        if (rst) begin
            init_q    <= 8'd0;
            idx       <= 3'd0;
            cnt       <= 8'd0;
            pass      <= 1'b0;
            err_count <= 4'd0;
            fail_idx  <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        init_q    <= init;
                        idx       <= 3'd0;
                        cnt       <= SETTLE_LOAD;
                        err_count <= 4'd0;
                        fail_idx  <= 3'd0;
                    end
                end
                SETTLE: begin
                    if (cnt != 8'd0) begin
                        cnt <= cnt - 8'd1;
                    end
                end
                CHECK: begin
                    err_count <= err_next;
                    if (mismatch && (err_count == 4'd0)) begin
                        fail_idx <= idx;
                    end
                    if (idx == 3'd7) begin
                        pass <= (err_next == 4'd0);
                    end else begin
                        idx <= idx + 3'd1;
                        cnt <= SETTLE_LOAD;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dut_i     = idx;
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign state_dbg = state;

endmodule

// File: tb/tb_lut3_sweep_ctrl.sv
// Directed bench for lut3_sweep_ctrl: one instance uses SETTLE_CYCLES=4 and a
// second uses SETTLE_CYCLES=1. Cycle n is the state seen just after the nth
// rising edge that follows the edge on which start is sampled.
module tb_lut3_sweep_ctrl;

    logic       clk;
    logic       rst;

    logic       start0;
    logic [7:0] init0;
    logic       dut_o0;
    logic [2:0] dut_i0;
    logic       busy0, done0, pass0;
    logic [3:0] err_count0;
    logic [2:0] fail_idx0;
    logic [1:0] state_dbg0;
    logic [7:0] lut0;

    logic       start1;
    logic [7:0] init1;
    logic       dut_o1;
    logic [2:0] dut_i1;
    logic       busy1, done1, pass1;
    logic [3:0] err_count1;
    logic [2:0] fail_idx1;
    logic [1:0] state_dbg1;
    logic [7:0] lut1;

    int checks;
    int failures;

    lut3_sweep_ctrl #(.SETTLE_CYCLES(4)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .init(init0), .dut_o(dut_o0),
        .dut_i(dut_i0), .busy(busy0), .done(done0), .pass(pass0),
        .err_count(err_count0), .fail_idx(fail_idx0), .state_dbg(state_dbg0)
    );

    lut3_sweep_ctrl #(.SETTLE_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .init(init1), .dut_o(dut_o1),
        .dut_i(dut_i1), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err_count1), .fail_idx(fail_idx1), .state_dbg(state_dbg1)
    );

    // Behavioural LUTs under control.
    assign dut_o0 = lut0[dut_i0];
    assign dut_o1 = lut1[dut_i1];

    // Clock and reset.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int observed, input int expected);
        checks++;
        if (observed != expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // One sweep on the SETTLE_CYCLES=4 instance.
    // repulse: extra start pulses at cycles 5, 20 and 41, and init is inverted from cycle 10 onward.
    // rst_cyc: cycle in which rst is held high, or -1 for none.
    task automatic sweep0(input logic [7:0] init_v, input logic [7:0] lut_v,
                          input bit repulse, input int rst_cyc,
                          output int done_cyc, output int done_cnt);
        done_cyc = -1;
        done_cnt = 0;
        lut0 = lut_v;
        for (int n = 1; n <= 46; n++) begin
            start0 = (n - 1 == 0) ||
                     (repulse && ((n - 1 == 5) || (n - 1 == 20) || (n - 1 == 41)));
            init0  = (repulse && (n - 1 >= 10)) ? ~init_v : init_v;
            rst    = (n - 1 == rst_cyc);
            @(posedge clk);
            #1;
            if (done0) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = n;
            end
            if (rst_cyc < 0 && (n % 5 == 0) && n <= 40) begin
                check($sformatf("dut_i@%0d", n), int'(dut_i0), n / 5 - 1);
                check($sformatf("check_state@%0d", n), int'(state_dbg0), 2);
            end
            if (rst_cyc < 0 && n == 20) check("busy_mid", int'(busy0), 1);
            if (rst_cyc < 0 && n == 42) check("idle_after_done", int'(busy0), 0);
            if (rst_cyc >= 0 && n == rst_cyc + 1) begin
                check("rst_state", int'(state_dbg0), 0);
                check("rst_busy", int'(busy0), 0);
                check("rst_done", int'(done0), 0);
                check("rst_pass", int'(pass0), 0);
                check("rst_dut_i", int'(dut_i0), 0);
                check("rst_err", int'(err_count0), 0);
                check("rst_fidx", int'(fail_idx0), 0);
            end
        end
        start0 = 1'b0;
        rst    = 1'b0;
    endtask

    initial begin
        int dc;
        int dn;
        checks   = 0;
        failures = 0;
        start0 = 1'b0; init0 = 8'h00; lut0 = 8'h00;
        start1 = 1'b0; init1 = 8'h00; lut1 = 8'h00;
        do_reset();

        check("reset_busy", int'(busy0), 0);
        check("reset_done", int'(done0), 0);
        check("reset_pass", int'(pass0), 0);
        check("reset_err", int'(err_count0), 0);
        check("reset_dut_i", int'(dut_i0), 0);

        // The LUT matches the expected table.
        sweep0(8'h83, 8'h83, 1'b0, -1, dc, dn);
        check("t1_done_cyc", dc, 41);
        check("t1_done_cnt", dn, 1);
        check("t1_pass", int'(pass0), 1);
        check("t1_err", int'(err_count0), 0);
        check("t1_fidx", int'(fail_idx0), 0);

        // Vector 2 reads 1 and vector 7 reads 0.
        sweep0(8'h83, 8'h07, 1'b0, -1, dc, dn);
        check("t2_done_cyc", dc, 41);
        check("t2_pass", int'(pass0), 0);
        check("t2_err", int'(err_count0), 2);
        check("t2_fidx", int'(fail_idx0), 2);

        // Every vector is inverted, so the count reaches its maximum.
        sweep0(8'h83, 8'h7C, 1'b0, -1, dc, dn);
        check("t3_pass", int'(pass0), 0);
        check("t3_err", int'(err_count0), 8);
        check("t3_fidx", int'(fail_idx0), 0);

        // Re-pulse start and change init mid-sweep; start during DONE must be ignored.
        sweep0(8'h83, 8'h83, 1'b1, -1, dc, dn);
        check("t4_done_cyc", dc, 41);
        check("t4_done_cnt", dn, 1);
        check("t4_pass", int'(pass0), 1);
        check("t4_err", int'(err_count0), 0);

        // Reset mid-sweep, then a clean sweep afterwards.
        sweep0(8'h83, 8'h83, 1'b0, 17, dc, dn);
        check("t5_no_done", dn, 0);
        sweep0(8'h83, 8'h83, 1'b0, -1, dc, dn);
        check("t5_restart_done_cyc", dc, 41);
        check("t5_restart_pass", int'(pass0), 1);

        // SETTLE_CYCLES=1 instance; expect a single mismatch at vector 7.
        dc = -1;
        dn = 0;
        init1 = 8'h5A;
        lut1  = 8'hDA;
        for (int n = 1; n <= 20; n++) begin
            start1 = (n - 1 == 0);
            @(posedge clk);
            #1;
            if (done1) begin
                dn++;
                if (dc < 0) dc = n;
            end
            if ((n % 2 == 0) && n <= 16) begin
                check($sformatf("s1_dut_i@%0d", n), int'(dut_i1), n / 2 - 1);
                check($sformatf("s1_check_state@%0d", n), int'(state_dbg1), 2);
            end
        end
        start1 = 1'b0;
        check("s1_done_cyc", dc, 17);
        check("s1_done_cnt", dn, 1);
        check("s1_pass", int'(pass1), 0);
        check("s1_err", int'(err_count1), 1);
        check("s1_fidx", int'(fail_idx1), 7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
